multi_peak_finder: RTL and testbench

Streaming top-K spectral peak detector, a parametrised successor to `peak_finder`. It consumes one FFT magnitude frame per `fft_last_in` (or per `N_BINS` beats) and tracks the `K` largest magnitudes above a runtime threshold within a configurable bin window. At frame end it hands the sorted list to a valid/ready output stream. It sits between `fft` and the note-mapping logic, so the chord/harmonic stage can see several simultaneous tones.

---
 rtl/peak_pkg.sv | 11 +
 rtl/peak_sorter.sv | 41 ++++
 rtl/multi_peak_finder.sv | 98 +++++++++
 tb/tb_multi_peak_finder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/peak_pkg.sv
// peak_pkg: shared entry type and output FSM states for the multi_peak_finder slice
package peak_pkg;
  localparam int PEAK_DATA_W = 16;
  localparam int PEAK_BIN_W = 12;
  typedef struct packed {
    logic                   valid;
    logic [PEAK_BIN_W-1:0]  bin;
    logic [PEAK_DATA_W-1:0] mag;
  } peak_entry_t;
  typedef enum logic {IDLE, EMIT} state_t;
endpackage

// File: rtl/peak_sorter.sv
// peak_sorter: K-entry descending-magnitude insertion list
// Ports: clk_i/rst_i clock and async reset, clr_i clears the list after this edge,
// ins_i/bin_i/mag_i candidate to insert, list_o flat post-insert list (entry 0 in low bits).
module peak_sorter
  import peak_pkg::*;
#(
  parameter int K      = 4,
  parameter int DATA_W = 16,
  parameter int BIN_W  = 12
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clr_i,
  input  logic                             ins_i,
  input  logic [BIN_W-1:0]                 bin_i,
  input  logic [DATA_W-1:0]                mag_i,
  output logic [K*(1+BIN_W+DATA_W)-1:0]    list_o
);
  localparam int W = 1 + BIN_W + DATA_W;
  typedef struct packed {
    logic              valid;
    logic [BIN_W-1:0]  bin;
    logic [DATA_W-1:0] mag;
  } entry_t;
  entry_t ent_q [K];
  entry_t ent_d [K];
  logic [K-1:0] gt;
  // gt is monotonic (0..0 1..1) because valid entries are sorted and packed at the head,
  // so the first set bit is the insertion point; strict > keeps earlier bins ahead on ties.
  always_comb begin
    list_o = '0;
    for (int i = 0; i < K; i++) gt[i] = !ent_q[i].valid || mag_i > ent_q[i].mag;
    ent_d[0] = ins_i && gt[0] ? entry_t'{1'b1, bin_i, mag_i} : ent_q[0];
    for (int i = 1; i < K; i++)
      ent_d[i] = !(ins_i && gt[i]) ? ent_q[i] : gt[i-1] ? ent_q[i-1] : entry_t'{1'b1, bin_i, mag_i};
    for (int i = 0; i < K; i++) list_o[i*W +: W] = ent_d[i];
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) for (int i = 0; i < K; i++) ent_q[i] <= '0;
    else for (int i = 0; i < K; i++) ent_q[i] <= clr_i ? '0 : ent_d[i];
endmodule

// File: rtl/multi_peak_finder.sv
// multi_peak_finder: streaming top-K spectral peak detector with valid/ready list output
// Ports: clk_in/rst_in clock and async reset; fft_* magnitude stream (no backpressure);
// threshold_in eligibility floor; peak_* sorted list stream; frame_done_out/peak_count_out
// list acceptance and size; overrun_out list dropped because the previous one is still emitting.
module multi_peak_finder
  import peak_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int N_BINS  = 4096,
  parameter int K       = 4,
  parameter int MIN_BIN = 1,
  parameter int MAX_BIN = 2047,
  localparam int BIN_W  = $clog2(N_BINS),
  localparam int RANK_W = K > 1 ? $clog2(K) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              fft_valid_in,
  input  logic              fft_last_in,
  input  logic [DATA_W-1:0] fft_data_in,
  input  logic [DATA_W-1:0] threshold_in,
  output logic              peak_valid_out,
  input  logic              peak_ready_in,
  output logic [BIN_W-1:0]  peak_bin_out,
  output logic [DATA_W-1:0] peak_mag_out,
  output logic [RANK_W-1:0] peak_rank_out,
  output logic              peak_last_out,
  output logic              frame_done_out,
  output logic [RANK_W:0]   peak_count_out,
  output logic              overrun_out
);
  localparam int EW = 1 + BIN_W + DATA_W;
  typedef struct packed {
    logic              valid;
    logic [BIN_W-1:0]  bin;
    logic [DATA_W-1:0] mag;
  } entry_t;
  logic [BIN_W-1:0]  bin_q;
  state_t            state_q;
  entry_t            buf_q [K];
  entry_t            nxt_e [K];
  logic [K*EW-1:0]   nxt;
  logic [RANK_W-1:0] rank_q;
  logic [RANK_W:0]   cnt_q, cnt_d;
  logic              done_q, ovr_q, elig, close, hs, last;
  assign elig  = fft_valid_in && bin_q >= BIN_W'(MIN_BIN) && bin_q <= BIN_W'(MAX_BIN) && fft_data_in > threshold_in;
  assign close = fft_valid_in && (fft_last_in || bin_q == BIN_W'(N_BINS-1));
  assign hs    = state_q == EMIT && peak_ready_in;
  assign last  = {1'b0, rank_q} == cnt_q - 1'b1;
  peak_sorter #(.K(K), .DATA_W(DATA_W), .BIN_W(BIN_W)) u_sorter (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .clr_i (close),
    .ins_i (elig),
    .bin_i (bin_q),
    .mag_i (fft_data_in),
    .list_o(nxt)
  );
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < K; i++) begin
      nxt_e[i] = nxt[i*EW +: EW];
      cnt_d    = cnt_d + {{RANK_W{1'b0}}, nxt_e[i].valid};
    end
  end
  // A close that coincides with the final handshake still sees EMIT and is dropped.
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      bin_q   <= '0;
      state_q <= IDLE;
      rank_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < K; i++) buf_q[i] <= '0;
    end else begin
      if (fft_valid_in) bin_q <= close ? '0 : bin_q + 1'b1;
      done_q <= close && state_q == IDLE;
      ovr_q  <= close && state_q == EMIT;
      if (close && state_q == IDLE) begin
        buf_q   <= nxt_e;
        cnt_q   <= cnt_d;
        rank_q  <= '0;
        state_q <= cnt_d != '0 ? EMIT : IDLE;
      end else if (hs) begin
        rank_q <= last ? '0 : rank_q + 1'b1;
        if (last) state_q <= IDLE;
      end
    end
  assign peak_valid_out = state_q == EMIT;
  assign peak_bin_out   = buf_q[rank_q].bin;
  assign peak_mag_out   = buf_q[rank_q].mag;
  assign peak_rank_out  = rank_q;
  assign peak_last_out  = peak_valid_out && last;
  assign frame_done_out = done_q;
  assign peak_count_out = cnt_q;
  assign overrun_out    = ovr_q;
endmodule

// File: tb/tb_multi_peak_finder.sv
// tb_multi_peak_finder: directed and randomized frames checked against a top-K reference model
module tb_multi_peak_finder;
  localparam int NB = 16;
  localparam int KK = 4;
  localparam int DW = 16;
  localparam int LO = 1;
  localparam int HI = 7;
  typedef struct {int bin; int mag; int rank; int last;} beat_t;
  logic          clk = 0, rst_in = 1, fft_valid_in = 0, fft_last_in = 0, peak_ready_in = 0;
  logic [DW-1:0] fft_data_in = '0, threshold_in = '0;
  logic          peak_valid_out, peak_last_out, frame_done_out, overrun_out;
  logic [3:0]    peak_bin_out;
  logic [DW-1:0] peak_mag_out;
  logic [1:0]    peak_rank_out;
  logic [2:0]    peak_count_out;
  logic [DW-1:0] fm [NB];
  int            exp_bin [KK];
  int            exp_mag [KK];
  int            exp_n, total = 0, bad = 0;
  bit            rnd_ready = 0, stall = 0;
  beat_t         rx [$];
  beat_t         prev, cur;
  always #5 clk = ~clk;
  multi_peak_finder #(.DATA_W(DW), .N_BINS(NB), .K(KK), .MIN_BIN(LO), .MAX_BIN(HI)) dut (
    .clk_in        (clk),
    .rst_in        (rst_in),
    .fft_valid_in  (fft_valid_in),
    .fft_last_in   (fft_last_in),
    .fft_data_in   (fft_data_in),
    .threshold_in  (threshold_in),
    .peak_valid_out(peak_valid_out),
    .peak_ready_in (peak_ready_in),
    .peak_bin_out  (peak_bin_out),
    .peak_mag_out  (peak_mag_out),
    .peak_rank_out (peak_rank_out),
    .peak_last_out (peak_last_out),
    .frame_done_out(frame_done_out),
    .peak_count_out(peak_count_out),
    .overrun_out   (overrun_out)
  );
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_in) stall = 0;
    else begin
      cur = '{int'(peak_bin_out), int'(peak_mag_out), int'(peak_rank_out), int'(peak_last_out)};
      if (stall) begin
        chk("stable_valid", int'(peak_valid_out), 1);
        chk("stable_bin", cur.bin, prev.bin);
        chk("stable_mag", cur.mag, prev.mag);
        chk("stable_rank", cur.rank, prev.rank);
        chk("stable_last", cur.last, prev.last);
      end
      if (peak_valid_out && peak_ready_in) rx.push_back(cur);
      stall = peak_valid_out && !peak_ready_in;
      prev = cur;
    end
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) peak_ready_in = ($urandom_range(0, 3) != 0);
  endtask
  task automatic clear_fm();
    foreach (fm[i]) fm[i] = '0;
  endtask
  // Expected list: repeatedly take the largest eligible magnitude; ascending scan with
  // strict > means the lowest bin wins a tie.
  task automatic model(input int n);
    bit used [NB];
    int best;
    foreach (used[i]) used[i] = 0;
    exp_n = 0;
    for (int r = 0; r < KK; r++) begin
      best = -1;
      for (int b = 0; b < n; b++)
        if (!used[b] && b >= LO && b <= HI && fm[b] > threshold_in && (best < 0 || fm[b] > fm[best])) best = b;
      if (best < 0) break;
      used[best] = 1;
      exp_bin[r] = best;
      exp_mag[r] = int'(fm[best]);
      exp_n++;
    end
  endtask
  task automatic send_frame(input int n, input int last_at, input int exp_done, input int exp_ovr);
    for (int b = 0; b < n; b++) begin
      tick();
      fft_valid_in = 1;
      fft_data_in  = fm[b];
      fft_last_in  = (b == last_at);
    end
    tick();
    fft_valid_in = 0;
    fft_last_in  = 0;
    chk("frame_done", int'(frame_done_out), exp_done);
    chk("overrun", int'(overrun_out), exp_ovr);
    if (exp_done != 0) chk("count", int'(peak_count_out), exp_n);
  endtask
  task automatic drain(input string tag);
    int t = 0;
    tick();
    chk({tag, "_done_pulse_end"}, int'(frame_done_out), 0);
    while (rx.size() < exp_n && t < 300) begin
      tick();
      t++;
    end
    repeat (3) tick();
    chk({tag, "_beats"}, rx.size(), exp_n);
    chk({tag, "_idle"}, int'(peak_valid_out), 0);
    for (int i = 0; i < exp_n && i < rx.size(); i++) begin
      chk({tag, "_bin"}, rx[i].bin, exp_bin[i]);
      chk({tag, "_mag"}, rx[i].mag, exp_mag[i]);
      chk({tag, "_rank"}, rx[i].rank, i);
      chk({tag, "_last"}, rx[i].last, int'(i == exp_n - 1));
    end
    rx.delete();
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, la;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(peak_valid_out), 0);
    chk("rst_bin", int'(peak_bin_out), 0);
    chk("rst_mag", int'(peak_mag_out), 0);
    chk("rst_rank", int'(peak_rank_out), 0);
    chk("rst_last", int'(peak_last_out), 0);
    chk("rst_done", int'(frame_done_out), 0);
    chk("rst_count", int'(peak_count_out), 0);
    chk("rst_overrun", int'(overrun_out), 0);
    rst_in = 0;
    peak_ready_in = 1;
    clear_fm(); fm[5] = 900; threshold_in = 0;
    model(16); send_frame(16, -1, 1, 0); drain("tone");
    clear_fm(); fm[2] = 100; fm[3] = 400; fm[4] = 250; fm[6] = 400; fm[7] = 50;
    model(16); send_frame(16, 15, 1, 0); drain("sort");
    clear_fm(); fm[0] = 5000; fm[9] = 5000; fm[3] = 30; threshold_in = 30;
    model(16); send_frame(16, -1, 1, 0); drain("window");
    threshold_in = 0;
    peak_ready_in = 0;
    clear_fm(); fm[2] = 100; fm[3] = 400; fm[4] = 250; fm[6] = 400; fm[7] = 50;
    model(16); send_frame(16, -1, 1, 0);
    repeat (4) tick();
    chk("stall_valid", int'(peak_valid_out), 1);
    foreach (fm[b]) fm[b] = DW'(b * 10 + 1);
    send_frame(16, -1, 0, 1);
    tick();
    chk("ovr_pulse_end", int'(overrun_out), 0);
    peak_ready_in = 1;
    drain("overrun");
    clear_fm(); fm[1] = 20;
    model(16); send_frame(16, -1, 1, 0); drain("post_ovr");
    clear_fm(); fm[3] = 700; fm[8] = 800;
    model(10); send_frame(10, 9, 1, 0); drain("early");
    clear_fm(); fm[0] = 5000; fm[1] = 600;
    model(16); send_frame(16, -1, 1, 0); drain("after_early");
    peak_ready_in = 0;
    clear_fm(); fm[2] = 10; fm[4] = 20;
    model(16); send_frame(16, -1, 1, 0);
    tick();
    chk("pre_rst_valid", int'(peak_valid_out), 1);
    @(posedge clk);
    #2 rst_in = 1;
    #1;
    chk("rst_emit_valid", int'(peak_valid_out), 0);
    chk("rst_emit_count", int'(peak_count_out), 0);
    tick(); tick();
    rst_in = 0;
    peak_ready_in = 1;
    rx.delete();
    repeat (10) tick();
    chk("rst_no_emit", rx.size(), 0);
    chk("rst_idle", int'(peak_valid_out), 0);
    rnd_ready = 1;
    for (int f = 0; f < 30; f++) begin
      foreach (fm[b]) fm[b] = DW'($urandom_range(0, 10) * 50);
      threshold_in = DW'($urandom_range(0, 300));
      if ($urandom_range(0, 2) == 0) begin
        la = -1;
        n = 16;
      end else begin
        la = $urandom_range(0, 15);
        n = la + 1;
      end
      model(n); send_frame(n, la, 1, 0); drain("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
